// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, byte-addressable word memory with sub-word load/store, MEM/WB register.
module mem_stage #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_halt,
  input  logic [DATA_W-1:0] i_ex_alu_result,
  input  logic [DATA_W-1:0] i_ex_store_data,
  input  logic [4:0]        i_ex_rd,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic              i_ex_mem_to_reg,
  input  logic [1:0]        i_ex_width,
  input  logic              i_ex_unsigned,
  output logic [4:0]        o_ex_m_rd,
  output logic              o_ex_m_reg_write,
  output logic [DATA_W-1:0] o_ex_m_alu_result,
  output logic [4:0]        o_m_wb_rd,
  output logic              o_m_wb_reg_write,
  output logic [DATA_W-1:0] o_m_wb_data_write,
  output logic              o_misaligned,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);
  logic [DATA_W-1:0] r_em_alu, r_em_sd;
  logic [4:0]        r_em_rd;
  logic              r_em_rw, r_em_mr, r_em_mw, r_em_m2r, r_em_uns;
  logic [1:0]        r_em_width;
  logic [4:0]        r_wb_rd;
  logic              r_wb_rw;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic              w_half, w_word, w_mis, w_we, w_load;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_rword, w_ld, w_wb_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_hword;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_em_alu   <= '0;
      r_em_sd    <= '0;
      r_em_rd    <= '0;
      r_em_rw    <= 1'b0;
      r_em_mr    <= 1'b0;
      r_em_mw    <= 1'b0;
      r_em_m2r   <= 1'b0;
      r_em_width <= '0;
      r_em_uns   <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_data  <= '0;
    end else if (!i_halt) begin
      r_em_alu   <= i_ex_alu_result;
      r_em_sd    <= i_ex_store_data;
      r_em_rd    <= i_ex_rd;
      r_em_rw    <= i_ex_reg_write;
      r_em_mr    <= i_ex_mem_read;
      r_em_mw    <= i_ex_mem_write;
      r_em_m2r   <= i_ex_mem_to_reg;
      r_em_width <= i_ex_width;
      r_em_uns   <= i_ex_unsigned;
      r_wb_rd    <= r_em_rd;
      r_wb_rw    <= r_em_rw & ~(w_mis & w_load);
      r_wb_data  <= w_wb_data;
    end

  always_comb begin
    w_word  = r_em_width[1];
    w_half  = r_em_width == 2'b01;
    w_idx   = r_em_alu[ADDR_W+1:2];
    w_mis   = (r_em_mr | r_em_mw) & ((w_half & r_em_alu[0]) | (w_word & (r_em_alu[1:0] != 2'b00)));
    w_load  = r_em_mr & ~r_em_mw;
    w_we    = r_em_mw & ~w_mis & ~i_halt;
    w_be    = w_word ? 4'hF : w_half ? (r_em_alu[1] ? 4'hC : 4'h3) : 4'b0001 << r_em_alu[1:0];
    w_wdata = w_word ? r_em_sd : w_half ? {2{r_em_sd[15:0]}} : {4{r_em_sd[7:0]}};
    w_rword = r_mem[w_idx];
    w_byte  = w_rword[{r_em_alu[1:0], 3'b000} +: 8];
    w_hword = w_rword[{r_em_alu[1], 4'b0000} +: 16];
    w_ld    = w_word ? w_rword
            : w_half ? (r_em_uns ? {16'b0, w_hword} : {{(DATA_W-16){w_hword[15]}}, w_hword})
            : (r_em_uns ? {24'b0, w_byte} : {{(DATA_W-8){w_byte[7]}}, w_byte});
    // A store with mem_read also set still writes back the ALU result.
    w_wb_data = (r_em_m2r & ~r_em_mw) ? (w_mis ? '0 : w_ld) : r_em_alu;
  end

  // Gating on i_rst_n keeps a store from committing on the edge reset is asserted.
  always_ff @(posedge i_clk)
    if (i_rst_n && w_we)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];

  assign o_ex_m_rd         = r_em_rd;
  assign o_ex_m_reg_write  = r_em_rw;
  assign o_ex_m_alu_result = r_em_alu;
  assign o_m_wb_rd         = r_wb_rd;
  assign o_m_wb_reg_write  = r_wb_rw;
  assign o_m_wb_data_write = r_wb_data;
  assign o_misaligned      = w_mis;
  assign o_dbg_data        = r_mem[i_dbg_addr];
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a byte-array reference model.
module tb_mem_stage;
  typedef struct packed {
    logic [31:0] alu, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
    logic [1:0]  w;
    logic        u;
  } inst_t;

  logic        i_clk = 0, i_rst_n = 0, i_halt = 0;
  logic [31:0] i_ex_alu_result = 0, i_ex_store_data = 0;
  logic [4:0]  i_ex_rd = 0;
  logic        i_ex_reg_write = 0, i_ex_mem_read = 0, i_ex_mem_write = 0, i_ex_mem_to_reg = 0, i_ex_unsigned = 0;
  logic [1:0]  i_ex_width = 0;
  logic [4:0]  o_ex_m_rd, o_m_wb_rd;
  logic        o_ex_m_reg_write, o_m_wb_reg_write, o_misaligned;
  logic [31:0] o_ex_m_alu_result, o_m_wb_data_write, o_dbg_data;
  logic [7:0]  i_dbg_addr = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_halt(i_halt),
    .i_ex_alu_result(i_ex_alu_result), .i_ex_store_data(i_ex_store_data),
    .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_mem_write(i_ex_mem_write), .i_ex_mem_to_reg(i_ex_mem_to_reg),
    .i_ex_width(i_ex_width), .i_ex_unsigned(i_ex_unsigned),
    .o_ex_m_rd(o_ex_m_rd), .o_ex_m_reg_write(o_ex_m_reg_write), .o_ex_m_alu_result(o_ex_m_alu_result),
    .o_m_wb_rd(o_m_wb_rd), .o_m_wb_reg_write(o_m_wb_reg_write), .o_m_wb_data_write(o_m_wb_data_write),
    .o_misaligned(o_misaligned), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] mb [1024];
  inst_t em = '0;
  logic [4:0]  wb_rd = 0;
  logic        wb_rw = 0;
  logic [31:0] wb_data = 0;
  bit          chk_dbg = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic inst_t mk(input logic [31:0] alu, sd, input logic [4:0] rd,
                               input logic rw, mr, mw, m2r, input logic [1:0] w, input logic u);
    mk = '{alu, sd, rd, rw, mr, mw, m2r, w, u};
  endfunction

  function automatic int size_of(input logic [1:0] w);
    size_of = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic mis_of(input inst_t x);
    mis_of = (x.mr || x.mw) && (int'(x.alu[9:0]) % size_of(x.w) != 0);
  endfunction

  function automatic logic [31:0] mword(input int idx);
    mword = {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
  endfunction

  // Retire the instruction leaving MEM: apply its store or compute its load result.
  task automatic exec(input inst_t x);
    int a, n;
    logic [31:0] v;
    logic mis;
    a = int'(x.alu[9:0]);
    n = size_of(x.w);
    mis = mis_of(x);
    v = 0;
    if (x.mw) begin
      if (!mis) for (int i = 0; i < n; i++) mb[a+i] = x.sd[8*i +: 8];
    end else if (x.mr && !mis) begin
      for (int i = 0; i < n; i++) v = v | (32'(mb[a+i]) << (8*i));
      if (!x.u && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!x.u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    end
    wb_rd   = x.rd;
    wb_rw   = x.rw && !(mis && x.mr && !x.mw);
    wb_data = (x.m2r && !x.mw) ? v : x.alu;
  endtask

  task automatic check_all();
    chk("ex_rd", 32'(o_ex_m_rd), 32'(em.rd));
    chk("ex_rw", 32'(o_ex_m_reg_write), 32'(em.rw));
    chk("ex_alu", o_ex_m_alu_result, em.alu);
    chk("misaligned", 32'(o_misaligned), 32'(mis_of(em)));
    chk("wb_rd", 32'(o_m_wb_rd), 32'(wb_rd));
    chk("wb_rw", 32'(o_m_wb_reg_write), 32'(wb_rw));
    chk("wb_data", o_m_wb_data_write, wb_data);
    if (chk_dbg) chk("dbg", o_dbg_data, mword(int'(i_dbg_addr)));
  endtask

  task automatic drive(input inst_t x);
    i_ex_alu_result = x.alu; i_ex_store_data = x.sd; i_ex_rd = x.rd;
    i_ex_reg_write = x.rw; i_ex_mem_read = x.mr; i_ex_mem_write = x.mw;
    i_ex_mem_to_reg = x.m2r; i_ex_width = x.w; i_ex_unsigned = x.u;
  endtask

  task automatic step(input inst_t x, input logic h);
    drive(x);
    i_halt = h;
    @(posedge i_clk);
    if (!h) begin
      exec(em);
      em = x;
    end
    #1 check_all();
  endtask

  task automatic dbg_chk(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    i_dbg_addr = idx;
    #1 chk(tag, o_dbg_data, exp);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ex_rd"}, 32'(o_ex_m_rd), 0);
    chk({tag, "_ex_rw"}, 32'(o_ex_m_reg_write), 0);
    chk({tag, "_ex_alu"}, o_ex_m_alu_result, 0);
    chk({tag, "_wb_rd"}, 32'(o_m_wb_rd), 0);
    chk({tag, "_wb_rw"}, 32'(o_m_wb_reg_write), 0);
    chk({tag, "_wb_data"}, o_m_wb_data_write, 0);
    chk({tag, "_mis"}, 32'(o_misaligned), 0);
  endtask

  localparam inst_t NOP = '0;

  function automatic inst_t sw(input logic [31:0] a, d);     sw = mk(a, d, 0, 0, 0, 1, 0, 2'd3, 0); endfunction
  function automatic inst_t st(input logic [31:0] a, d, input logic [1:0] w); st = mk(a, d, 0, 0, 0, 1, 0, w, 0); endfunction
  function automatic inst_t ld(input logic [31:0] a, input logic [1:0] w, input logic u);
    ld = mk(a, 0, 5'd9, 1, 1, 0, 1, w, u);
  endfunction

  initial begin
    inst_t x;
    // Reset with busy inputs
    drive(mk(32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 1, 1, 1, 1, 2'd3, 1));
    i_halt = 0;
    repeat (2) @(posedge i_clk);
    #1 reset_chk("rst");
    drive(NOP);
    i_rst_n = 1;
    step(NOP, 0);
    step(NOP, 0);
    reset_chk("post_rst");
    // Zero the whole memory so model and DUT agree
    for (int k = 0; k < 256; k++) step(sw(32'(k) << 2, 0), 0);
    step(NOP, 0);
    for (int k = 0; k < 1024; k++) mb[k] = 0;
    chk_dbg = 1;
    // SW then LW
    step(sw(32'h10, 32'hDEAD_BEEF), 0);
    step(ld(32'h10, 2'd3, 0), 0);
    step(NOP, 0);
    chk("t2_lw", o_m_wb_data_write, 32'hDEAD_BEEF);
    dbg_chk("t2_dbg", 8'd4, 32'hDEAD_BEEF);
    // SB over a zero word, signed and unsigned byte loads
    step(sw(32'h10, 0), 0);
    step(st(32'h11, 32'h80, 2'd0), 0);
    step(ld(32'h11, 2'd0, 0), 0);
    step(ld(32'h11, 2'd0, 1), 0);
    chk("t3_lb", o_m_wb_data_write, 32'hFFFF_FF80);
    step(NOP, 0);
    chk("t3_lbu", o_m_wb_data_write, 32'h0000_0080);
    dbg_chk("t3_dbg", 8'd4, 32'h0000_8000);
    // SH/LH and misaligned accesses
    step(st(32'h22, 32'hABCD, 2'd1), 0);
    step(ld(32'h22, 2'd1, 0), 0);
    step(ld(32'h21, 2'd3, 0), 0);
    chk("t4_lh", o_m_wb_data_write, 32'hFFFF_ABCD);
    chk("t4_mis", 32'(o_misaligned), 1);
    step(sw(32'h22, 32'h1111_1111), 0);
    chk("t4_mis_rw", 32'(o_m_wb_reg_write), 0);
    step(NOP, 0);
    step(NOP, 0);
    dbg_chk("t4_dbg", 8'd8, 32'hABCD_0000);
    // Plain ALU op
    step(mk(32'h1234_5678, 0, 5'd4, 1, 0, 0, 0, 2'd3, 0), 0);
    chk("t5_ex_rd", 32'(o_ex_m_rd), 4);
    chk("t5_ex_alu", o_ex_m_alu_result, 32'h1234_5678);
    step(NOP, 0);
    chk("t5_wb_rd", 32'(o_m_wb_rd), 4);
    chk("t5_wb_data", o_m_wb_data_write, 32'h1234_5678);
    // Halt with a store sitting in EX/MEM
    step(sw(32'h40, 32'hCAFE_F00D), 0);
    i_dbg_addr = 8'd16;
    for (int k = 0; k < 3; k++) begin
      step(ld(32'h40, 2'd3, 0), 1);
      chk("t6_halt_dbg", o_dbg_data, 0);
    end
    step(ld(32'h40, 2'd3, 0), 0);
    chk("t6_commit", o_dbg_data, 32'hCAFE_F00D);
    step(NOP, 0);
    chk("t6_reload", o_m_wb_data_write, 32'hCAFE_F00D);
    // Reset while a store is in flight
    step(sw(32'h80, 32'h5A5A_5A5A), 0);
    #2 i_rst_n = 0;
    #1 reset_chk("mid_rst");
    @(posedge i_clk);
    #1 dbg_chk("mid_rst_dbg", 8'd32, 0);
    em = '0; wb_rd = 0; wb_rw = 0; wb_data = 0;
    drive(NOP);
    i_rst_n = 1;
    step(NOP, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      x.alu = $urandom;
      if ($urandom_range(0, 3) != 0) x.alu[9:5] = 0;
      x.sd = $urandom;
      x.rd = 5'($urandom);
      x.rw = 1'($urandom);
      x.w = 2'($urandom);
      x.u = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin x.mr = 0; x.mw = 0; x.m2r = 0; end
        1: begin x.mr = 1; x.mw = 0; x.m2r = 1; end
        2: begin x.mr = 0; x.mw = 1; x.m2r = 0; end
        default: begin x.mr = 1; x.mw = 1; x.m2r = 1'($urandom); end
      endcase
      i_dbg_addr = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      step(x, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
